div_share_arb: RTL



---
 rtl/div_share_arb_if.sv | 31 +++
 rtl/div_share_arb.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/div_share_arb_if.sv
// Bundle for div_share_arb: requester handshake, shared-divider drive/return and response bus.
// Signal names match the block's port list; clock and aclr stay outside the bundle.
interface div_share_arb_if #(
    parameter int N  = 3,
    parameter int NW = 10,
    parameter int DW = 4
);
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*NW-1:0] req_numer;
    logic [N*DW-1:0] req_denom;
    logic [NW-1:0]   div_numer;
    logic [DW-1:0]   div_denom;
    logic [NW-1:0]   div_quotient;
    logic [DW-1:0]   div_remain;
    logic [N-1:0]    rsp_valid;
    logic [NW-1:0]   rsp_quotient;
    logic [DW-1:0]   rsp_remain;
    logic            rsp_div0;
    logic            busy;

    modport slave (
        input  req_valid, req_numer, req_denom, div_quotient, div_remain,
        output req_ready, div_numer, div_denom, rsp_valid, rsp_quotient, rsp_remain, rsp_div0, busy
    );

    modport master (
        output req_valid, req_numer, req_denom, div_quotient, div_remain,
        input  req_ready, div_numer, div_denom, rsp_valid, rsp_quotient, rsp_remain, rsp_div0, busy
    );
endinterface

// File: rtl/div_share_arb.sv
// Round-robin scheduler sharing one external pipelined divider among N requesters.
// Optional macro DIV_SHARE_ARB_DIV0_EN: flag zero-denominator results (quotient all ones, remainder 0).
module div_share_arb #(
    parameter int N       = 3,
    parameter int NW      = 10,
    parameter int DW      = 4,
    parameter int DIV_LAT = 1
) (
    input logic            clock,
    input logic            aclr,
    div_share_arb_if.slave bus
);
    localparam int IW = $clog2(N);
    localparam int CW = IW + 1;

    logic [NW-1:0]      numer_arr [N];
    logic [DW-1:0]      denom_arr [N];
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [IW-1:0]      sel_q, sel_d;
    logic [IW-1:0]      grant_idx;
    logic               grant_vld;
    logic [CW-1:0]      cand;
    logic [N-1:0]       grant_oh;
    logic [N-1:0]       last_oh;
    logic [DIV_LAT-1:0] tag_v_q;
    logic [IW-1:0]      tag_idx_q [DIV_LAT];
    logic [N-1:0]       rsp_valid_q;
    logic [NW-1:0]      rsp_quotient_q;
    logic [DW-1:0]      rsp_remain_q;

    for (genvar gi = 0; gi < N; gi++) begin : g_req
        assign numer_arr[gi] = bus.req_numer[gi*NW +: NW];
        assign denom_arr[gi] = bus.req_denom[gi*DW +: DW];
        assign grant_oh[gi]  = grant_vld && (grant_idx == IW'(gi));
        assign last_oh[gi]   = (tag_idx_q[DIV_LAT-1] == IW'(gi));
    end

    // Scan from the far end back toward ptr so the last hit is the first valid at or after ptr.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = {1'b0, ptr_q} + CW'(k);
            if (cand >= CW'(N)) begin
                cand = cand - CW'(N);
            end
            if (bus.req_valid[cand[IW-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = cand[IW-1:0];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        sel_d = sel_q;
        if (grant_vld) begin
            sel_d = grant_idx;
            ptr_d = (grant_idx == IW'(N - 1)) ? '0 : grant_idx + IW'(1);
        end
    end

    // Idle cycles keep the last issued select so the divider inputs stay quiet.
    assign bus.req_ready = grant_oh;
    assign bus.div_numer = numer_arr[sel_d];
    assign bus.div_denom = denom_arr[sel_d];

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            ptr_q <= '0;
            sel_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            sel_q <= sel_d;
        end
    end

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            tag_v_q <= '0;
            for (int s = 0; s < DIV_LAT; s++) begin
                tag_idx_q[s] <= '0;
            end
        end else begin
            tag_v_q[0]   <= grant_vld;
            tag_idx_q[0] <= grant_idx;
            for (int s = 1; s < DIV_LAT; s++) begin
                tag_v_q[s]   <= tag_v_q[s-1];
                tag_idx_q[s] <= tag_idx_q[s-1];
            end
        end
    end

`ifdef DIV_SHARE_ARB_DIV0_EN
    logic [DIV_LAT-1:0] tag_z_q;
    logic               rsp_div0_q;

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            tag_z_q <= '0;
        end else begin
            tag_z_q[0] <= grant_vld && (bus.div_denom == '0);
            for (int s = 1; s < DIV_LAT; s++) begin
                tag_z_q[s] <= tag_z_q[s-1];
            end
        end
    end

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            rsp_valid_q    <= '0;
            rsp_quotient_q <= '0;
            rsp_remain_q   <= '0;
            rsp_div0_q     <= 1'b0;
        end else if (tag_v_q[DIV_LAT-1]) begin
            rsp_valid_q <= last_oh;
            rsp_div0_q  <= tag_z_q[DIV_LAT-1];
            if (tag_z_q[DIV_LAT-1]) begin
                rsp_quotient_q <= '1;
                rsp_remain_q   <= '0;
            end else begin
                rsp_quotient_q <= bus.div_quotient;
                rsp_remain_q   <= bus.div_remain;
            end
        end else begin
            rsp_valid_q <= '0;
        end
    end

    assign bus.rsp_div0 = rsp_div0_q;
`else
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            rsp_valid_q    <= '0;
            rsp_quotient_q <= '0;
            rsp_remain_q   <= '0;
        end else if (tag_v_q[DIV_LAT-1]) begin
            rsp_valid_q    <= last_oh;
            rsp_quotient_q <= bus.div_quotient;
            rsp_remain_q   <= bus.div_remain;
        end else begin
            rsp_valid_q <= '0;
        end
    end

    assign bus.rsp_div0 = 1'b0;
`endif

    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_quotient = rsp_quotient_q;
    assign bus.rsp_remain   = rsp_remain_q;
    assign bus.busy         = (|tag_v_q) | (|rsp_valid_q);
endmodule
